simon_3264: RTL and testbench

- Iterative SIMON block-cipher core, one round per clock; encrypts or decrypts one 2N-bit block under an M-word key.
- Default configuration is SIMON 48/72 (N=24, M=3, T=36).
- Sits between a host interface and a data path. It uses level-request / pulse-acknowledge handshakes for key load, block load and result read.
- The full round-key schedule is stored internally, so decryption needs no recomputation.

---
 rtl/simon_pkg.sv | 50 +++++
 rtl/simon_3264_keysched.sv | 63 ++++++
 rtl/simon_3264.sv | 148 ++++++++++++++
 tb/tb_simon_3264.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared constants, state codes and word-level helpers for the SIMON core.
package simon_pkg;

    // z sequences; the leftmost digit is element 0 of the sequence.
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_KEYEXP = 4'd1,
        ST_RUN    = 4'd2,
        ST_DONE   = 4'd3
    } state_t;

    // z sequence for a given word width n and key word count m.
    function automatic logic [61:0] z_select(input int n, input int m);
        logic [61:0] z;
        if (n == 16)      z = Z0;
        else if (n == 24) z = (m == 3) ? Z0 : Z1;
        else if (n == 32) z = (m == 3) ? Z2 : Z3;
        else if (n == 48) z = (m == 2) ? Z2 : Z3;
        else              z = (m == 2) ? Z2 : ((m == 3) ? Z3 : Z4);
        return z;
    endfunction

    function automatic logic [63:0] width_mask(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    // Rotations operate on the low n bits of a 64-bit carrier.
    function automatic logic [63:0] rol(input logic [63:0] a, input int s, input int n);
        logic [63:0] m;
        logic [63:0] v;
        m = width_mask(n);
        v = a & m;
        return ((v << s) | (v >> (n - s))) & m;
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] a, input int s, input int n);
        return rol(a, n - s, n);
    endfunction

    function automatic logic [63:0] simon_f(input logic [63:0] a, input int n);
        return (rol(a, 1, n) & rol(a, 8, n)) ^ rol(a, 2, n);
    endfunction

endpackage

// File: rtl/simon_3264_keysched.sv
// Round-key register file: captures the user key, expands one word per
// cycle, and serves any round key through a single indexed read port.
module simon_3264_keysched
    import simon_pkg::*;
#(
    parameter int N  = 24,
    parameter int M  = 3,
    parameter int T  = 36,
    parameter int Co = 6
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic                  load,
    input  logic [M-1:0][N-1:0]   key,
    input  logic                  expand,
    input  logic [Co-1:0]         rd_idx,
    output logic [N-1:0]          rk_rd,
    output logic                  exp_last,
    output logic                  done_key
);

    localparam logic [61:0] ZSEQ = z_select(N, M);

    logic [N-1:0]  rk [T];
    logic [Co-1:0] wr_idx;
    logic [5:0]    z_idx;
    logic [N-1:0]  t_rot;
    logic [N-1:0]  t_mix;
    logic [N-1:0]  t_fold;
    logic [N-1:0]  rk_new;

    // Next schedule word from the previous M words and the z sequence.
    always_comb begin
        t_rot  = N'(ror(64'(rk[wr_idx - Co'(1)]), 3, N));
        t_mix  = (M == 4) ? (t_rot ^ rk[wr_idx - Co'(3)]) : t_rot;
        t_fold = t_mix ^ N'(ror(64'(t_mix), 1, N));
        rk_new = ~rk[wr_idx - Co'(M)] ^ t_fold ^ N'(ZSEQ[6'd61 - z_idx]) ^ N'(3);
    end

    // Key capture, word-per-cycle expansion and schedule-valid flag.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            for (int i = 0; i < T; i++) rk[i] <= '0;
            wr_idx   <= '0;
            z_idx    <= '0;
            done_key <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < M; i++) rk[i] <= key[i];
            wr_idx   <= Co'(M);
            z_idx    <= '0;
            done_key <= 1'b0;
        end else if (expand) begin
            rk[wr_idx] <= rk_new;
            wr_idx     <= wr_idx + Co'(1);
            z_idx      <= (z_idx == 6'd61) ? 6'd0 : z_idx + 6'd1;
            if (exp_last) done_key <= 1'b1;
        end
    end

    assign exp_last = (wr_idx == Co'(T - 1));
    assign rk_rd    = rk[rd_idx];

endmodule

// File: rtl/simon_3264.sv
// Iterative SIMON core: one round per clock, stored key schedule, and
// level-request / pulse-acknowledge handshakes for key, block and result.
//
//   state  | meaning
//   IDLE   | waiting for newKey (priority) or newData with a valid schedule
//   KEYEXP | expanding round keys M..T-1, one per cycle
//   RUN    | T rounds, then one edge to publish the result
//   DONE   | result held until readData
module simon_3264
    import simon_pkg::*;
#(
    parameter int N  = 24,
    parameter int M  = 3,
    parameter int T  = 36,
    parameter int Co = 6
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic                  newKey,
    input  logic [M-1:0][N-1:0]   KEY,
    input  logic                  newData,
    input  logic [1:0][N-1:0]     BLOCK,
    input  logic                  enc_dec,
    input  logic                  readData,
    output logic                  loadKey,
    output logic                  doneKey,
    output logic                  loadData,
    output logic                  doneData,
    output logic [1:0][N-1:0]     outData,
    output logic [3:0]            mode
);

    state_t        state;
    state_t        state_nx;
    logic          cap_key;
    logic          cap_data;
    logic          rd_ack;
    logic          exp_last;
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic          dec;
    logic          fin;
    logic [Co-1:0] rcnt;
    logic [Co-1:0] rk_idx;
    logic [N-1:0]  rk;
    logic [N-1:0]  f_x;
    logic [N-1:0]  f_y;

    simon_3264_keysched #(.N(N), .M(M), .T(T), .Co(Co)) u_keysched (
        .clk      (clk),
        .nR       (nR),
        .load     (cap_key),
        .key      (KEY),
        .expand   (state == ST_KEYEXP),
        .rd_idx   (rk_idx),
        .rk_rd    (rk),
        .exp_last (exp_last),
        .done_key (doneKey)
    );

    // State register.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and capture strobes.
    always_comb begin
        state_nx = state;
        cap_key  = 1'b0;
        cap_data = 1'b0;
        rd_ack   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (newKey) begin
                    cap_key  = 1'b1;
                    state_nx = ST_KEYEXP;
                end else if (newData && doneKey) begin
                    cap_data = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_KEYEXP: if (exp_last) state_nx = ST_IDLE;
            ST_RUN:    if (fin) state_nx = ST_DONE;
            ST_DONE: begin
                if (readData) begin
                    rd_ack   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Decryption walks the schedule backwards.
    assign rk_idx = dec ? (Co'(T - 1) - rcnt) : rcnt;
    assign f_x    = N'(simon_f(64'(x), N));
    assign f_y    = N'(simon_f(64'(y), N));

    // Block capture and one Feistel round per cycle while in RUN.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            x    <= '0;
            y    <= '0;
            dec  <= 1'b0;
            rcnt <= '0;
            fin  <= 1'b0;
        end else if (cap_data) begin
            x    <= BLOCK[1];
            y    <= BLOCK[0];
            dec  <= ~enc_dec;
            rcnt <= '0;
            fin  <= 1'b0;
        end else if (state == ST_RUN && !fin) begin
            if (dec) begin
                x <= y;
                y <= x ^ f_y ^ rk;
            end else begin
                x <= y ^ f_x ^ rk;
                y <= x;
            end
            rcnt <= rcnt + Co'(1);
            if (rcnt == Co'(T - 1)) fin <= 1'b1;
        end
    end

    // Handshake pulses and the held result.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            loadKey  <= 1'b0;
            loadData <= 1'b0;
            doneData <= 1'b0;
            outData  <= '0;
        end else begin
            loadKey  <= cap_key;
            loadData <= cap_data;
            if (state == ST_RUN && fin) begin
                outData  <= {x, y};
                doneData <= 1'b1;
            end else if (rd_ack) begin
                doneData <= 1'b0;
            end
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_simon_3264.sv
// Bench for simon_3264: a functional SIMON model plus a cycle monitor that
// predicts every handshake output and the result while it is held.
module tb_simon_3264;

    localparam int N  = 24;
    localparam int M  = 3;
    localparam int T  = 36;
    localparam int Co = 6;
    localparam int unsigned MASK = 32'h00FF_FFFF;

    localparam logic [M*N-1:0] KEY_VEC = 72'h121110_0A0908_020100;
    localparam logic [47:0]    PT_VEC  = 48'h6120676E696C;
    localparam logic [47:0]    CT_VEC  = 48'hDAE5AC292CAC;

    logic clk = 1'b0;
    logic nR = 1'b0;
    logic newKey = 1'b0;
    logic newData = 1'b0;
    logic enc_dec = 1'b0;
    logic readData = 1'b0;
    logic [M-1:0][N-1:0] KEY = '0;
    logic [1:0][N-1:0]   BLOCK = '0;
    logic loadKey, doneKey, loadData, doneData;
    logic [1:0][N-1:0] outData;
    logic [3:0] mode;

    int n_checks = 0;
    int n_errors = 0;
    int n_loads = 0;

    simon_3264 #(.N(N), .M(M), .T(T), .Co(Co)) dut (
        .clk(clk), .nR(nR), .newKey(newKey), .KEY(KEY), .newData(newData),
        .BLOCK(BLOCK), .enc_dec(enc_dec), .readData(readData),
        .loadKey(loadKey), .doneKey(doneKey), .loadData(loadData),
        .doneData(doneData), .outData(outData), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- functional SIMON model ----------------
    string zs = "11111010001001010110000111001101111101000100101011000011100110";
    logic [N-1:0] m_rk [T];

    function automatic int unsigned rotl(input int unsigned a, input int s);
        int unsigned v;
        v = a & MASK;
        return ((v << s) | (v >> (N - s))) & MASK;
    endfunction

    function automatic int unsigned fr(input int unsigned a);
        return (rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2);
    endfunction

    task automatic expand_key(input logic [M-1:0][N-1:0] k);
        int unsigned w [T];
        int unsigned t;
        int unsigned zb;
        for (int i = 0; i < M; i++) w[i] = 32'(k[i]);
        for (int i = M; i < T; i++) begin
            t = rotl(w[i-1], N - 3);
            if (M == 4) t = t ^ w[i-3];
            t = t ^ rotl(t, N - 1);
            zb = (zs[(i - M) % 62] == 8'h31) ? 32'd1 : 32'd0;
            w[i] = ((~w[i-M]) & MASK) ^ t ^ zb ^ 32'd3;
        end
        for (int i = 0; i < T; i++) m_rk[i] = N'(w[i]);
    endtask

    function automatic logic [2*N-1:0] crypt(input logic [2*N-1:0] blk, input logic enc);
        int unsigned a, b, t;
        a = 32'(blk[2*N-1:N]);
        b = 32'(blk[N-1:0]);
        for (int r = 0; r < T; r++) begin
            if (enc) begin
                t = a;
                a = b ^ fr(a) ^ 32'(m_rk[r]);
                b = t;
            end else begin
                t = b;
                b = a ^ fr(b) ^ 32'(m_rk[T-1-r]);
                a = t;
            end
        end
        return {N'(a), N'(b)};
    endfunction

    // ---------------- cycle monitor ----------------
    logic [M-1:0][N-1:0] key_s = '0;
    logic [2*N-1:0] blk_s = '0;
    logic ed_s = 1'b0, nk_s = 1'b0, nd_s = 1'b0, rd_s = 1'b0, nr_s = 1'b0;
    int krem = 0, drem = 0;
    logic exp_dk = 1'b0, exp_dd = 1'b0;
    logic [2*N-1:0] exp_out = '0;
    logic idle_e, exp_lk, exp_ld;
    logic [3:0] exp_mode;

    // Inputs change only at posedge+2, so the previous negedge snapshot is
    // exactly what the DUT saw at the edge that just passed.
    always @(negedge clk) begin
        if (!nR || !nr_s) begin
            krem = 0; drem = 0; exp_dk = 1'b0; exp_dd = 1'b0; exp_out = '0;
            check("reset_outputs", 64'({loadKey, doneKey, loadData, doneData, outData, mode}), 64'd0);
        end else begin
            idle_e = (krem == 0) && (drem == 0) && !exp_dd;
            exp_lk = idle_e && nk_s;
            exp_ld = idle_e && !nk_s && nd_s && exp_dk;
            if (exp_dd && rd_s) exp_dd = 1'b0;
            if (drem > 0) begin
                drem--;
                if (drem == 0) exp_dd = 1'b1;
            end
            if (krem > 0) begin
                krem--;
                if (krem == 0) exp_dk = 1'b1;
            end
            if (exp_lk) begin
                exp_dk = 1'b0;
                krem = T - M;
                expand_key(key_s);
            end
            if (exp_ld) begin
                drem = T + 1;
                exp_out = crypt(blk_s, ed_s);
            end
            exp_mode = (krem > 0) ? 4'd1 : (drem > 0) ? 4'd2 : exp_dd ? 4'd3 : 4'd0;
            check("loadKey", 64'(loadKey), 64'(exp_lk));
            check("loadData", 64'(loadData), 64'(exp_ld));
            check("doneKey", 64'(doneKey), 64'(exp_dk));
            check("doneData", 64'(doneData), 64'(exp_dd));
            check("mode", 64'(mode), 64'(exp_mode));
            if (exp_dd) check("outData", 64'(outData), 64'(exp_out));
            if (loadData) n_loads++;
        end
        key_s = KEY; blk_s = BLOCK; ed_s = enc_dec;
        nk_s = newKey; nd_s = newData; rd_s = readData; nr_s = nR;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic sig_now(input int s);
        case (s)
            0: return loadKey;
            1: return doneKey;
            2: return loadData;
            default: return doneData;
        endcase
    endfunction

    task automatic wait_sig(input int s, input string name);
        int i;
        i = 0;
        while (!sig_now(s) && i < 200) begin
            tick();
            i++;
        end
        check({name, "_seen"}, 64'(sig_now(s)), 64'd1);
    endtask

    task automatic read_out(input int d);
        repeat (d) tick();
        readData = 1'b1;
        tick();
        readData = 1'b0;
    endtask

    task automatic load_key(input logic [M*N-1:0] k);
        KEY = k;
        newKey = 1'b1;
        wait_sig(0, "load_key");
        newKey = 1'b0;
        KEY = 72'({$urandom, $urandom, $urandom});
        wait_sig(1, "done_key");
    endtask

    task automatic run_block(input logic [47:0] blk, input logic ed, input int rdelay,
                             output logic [47:0] res);
        BLOCK = blk;
        enc_dec = ed;
        newData = 1'b1;
        wait_sig(2, "load_data");
        newData = 1'b0;
        BLOCK = 48'({$urandom, $urandom});
        enc_dec = 1'($urandom);
        wait_sig(3, "done_data");
        res = outData;
        read_out(rdelay);
    endtask

    logic [47:0] pts [5] = '{48'h6120676E696C, 48'hA8D5F7DE0123, 48'h5BC92D014567,
                             48'hF2B48D4589AB, 48'h567F11DECDEF};
    logic [47:0] cts [5];
    logic [47:0] res, res2, blk;
    logic [M*N-1:0] kr;
    logic ed;
    int loads_before;

    initial begin
        // Pin the model against the published vector.
        expand_key(KEY_VEC);
        check("model_enc_vector", 64'(crypt(PT_VEC, 1'b1)), 64'(CT_VEC));
        check("model_dec_vector", 64'(crypt(CT_VEC, 1'b0)), 64'(PT_VEC));

        repeat (3) tick();
        check("reset_mode", 64'(mode), 64'd0);
        check("reset_doneKey", 64'(doneKey), 64'd0);
        nR = 1'b1;
        tick();

        // newKey and newData together: key first, data right after doneKey.
        KEY = KEY_VEC; BLOCK = PT_VEC; enc_dec = 1'b1;
        newKey = 1'b1; newData = 1'b1;
        wait_sig(0, "prio_load_key");
        newKey = 1'b0;
        wait_sig(1, "prio_done_key");
        check("prio_no_early_load", 64'(loadData), 64'd0);
        tick();
        check("prio_load_after_key", 64'(loadData), 64'd1);
        BLOCK = 48'h0123456789AB; enc_dec = 1'b0;
        wait_sig(3, "vec_done");
        check("vec_enc_out", 64'(outData), 64'(CT_VEC));

        // Stall in DONE with newData pending.
        repeat (100) tick();
        check("stall_mode", 64'(mode), 64'd3);
        check("stall_out", 64'(outData), 64'(CT_VEC));
        check("stall_doneData", 64'(doneData), 64'd1);
        readData = 1'b1;
        tick();
        readData = 1'b0;
        check("read_clears_done", 64'(doneData), 64'd0);
        tick();
        check("pending_loads_next", 64'(loadData), 64'd1);
        newData = 1'b0;
        wait_sig(3, "pending_done");
        read_out(1);

        // Decrypt the vector.
        run_block(CT_VEC, 1'b0, 2, res);
        check("vec_dec_out", 64'(res), 64'(PT_VEC));

        // Stream of five with newData raised while the previous result waits.
        BLOCK = pts[0]; enc_dec = 1'b1; newData = 1'b1;
        for (int b = 0; b < 5; b++) begin
            wait_sig(2, "stream_load");
            newData = 1'b0;
            enc_dec = 1'($urandom);
            wait_sig(3, "stream_done");
            cts[b] = outData;
            tick();
            if (b < 4) begin
                BLOCK = pts[b+1]; enc_dec = 1'b1; newData = 1'b1;
            end
            tick();
            tick();
            readData = 1'b1;
            tick();
            readData = 1'b0;
        end

        // Reset at round 10 of a run.
        BLOCK = 48'({$urandom, $urandom}); enc_dec = 1'b1; newData = 1'b1;
        wait_sig(2, "abort_load");
        newData = 1'b0;
        repeat (10) tick();
        nR = 1'b0;
        #1;
        check("abort_outputs", 64'({loadKey, loadData, doneData, outData}), 64'd0);
        check("abort_doneKey", 64'(doneKey), 64'd0);
        check("abort_mode", 64'(mode), 64'd0);
        tick();
        nR = 1'b1;
        loads_before = n_loads;
        newData = 1'b1;
        repeat (50) tick();
        check("no_load_without_key", 64'(n_loads - loads_before), 64'd0);
        check("abort_key_invalid", 64'(doneKey), 64'd0);
        load_key(KEY_VEC);
        tick();
        check("reload_then_load", 64'(loadData), 64'd1);
        newData = 1'b0;
        wait_sig(3, "reload_done");
        read_out(0);
        for (int b = 0; b < 5; b++) begin
            run_block(cts[b], 1'b0, b % 3, res);
            check("stream_roundtrip", 64'(res), 64'(pts[b]));
        end

        // newKey during RUN/DONE waits for IDLE; current block keeps old keys.
        BLOCK = 48'({$urandom, $urandom}); enc_dec = 1'b1; newData = 1'b1;
        wait_sig(2, "defer_load");
        newData = 1'b0;
        KEY = 72'({$urandom, $urandom, $urandom});
        newKey = 1'b1;
        wait_sig(3, "defer_done");
        read_out(1);
        wait_sig(0, "defer_key_load");
        newKey = 1'b0;
        wait_sig(1, "defer_key_done");

        // Randomized keys and blocks with roundtrip checks.
        for (int k = 0; k < 3; k++) begin
            kr = 72'({$urandom, $urandom, $urandom});
            load_key(kr);
            for (int j = 0; j < 6; j++) begin
                blk = 48'({$urandom, $urandom});
                ed = 1'($urandom);
                run_block(blk, ed, int'($urandom_range(0, 3)), res);
                run_block(res, ~ed, int'($urandom_range(0, 3)), res2);
                check("random_roundtrip", 64'(res2), 64'(blk));
            end
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
